// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog_if
// Description : Control/status bundle for the programmable multi-channel
//               clock divider. The master side drives the count enables,
//               the phase-align strobe and the divisor write port; the slave
//               side (the divider) returns the divided clocks, period ticks,
//               pending-update flags and the write-rejection pulse.
// Signals     : en[NCH]       per-channel count enable
//               sync_clr      phase-align all channels
//               div_wr        divisor write strobe
//               div_ch[CW]    target channel of the write
//               div_val[DW]   new divisor N
//               clk_out[NCH]  divided clocks (registered)
//               tick[NCH]     one-cycle pulse at the start of each period
//               pend[NCH]     divisor update waiting for the next wrap
//               div_err       one-cycle pulse after a rejected write
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
    parameter int NCH = 4,
    parameter int DW  = 32
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] en;
    logic           sync_clr;
    logic           div_wr;
    logic [CW-1:0]  div_ch;
    logic [DW-1:0]  div_val;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;
    logic           div_err;

    modport master (
        output en, sync_clr, div_wr, div_ch, div_val,
        input  clk_out, tick, pend, div_err
    );

    modport slave (
        input  en, sync_clr, div_wr, div_ch, div_val,
        output clk_out, tick, pend, div_err
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : NCH independent programmable clock dividers. Each channel
//               counts 0..A-1 and drives a registered divided clock that is
//               high for the first A-floor(A/2) counts of every period, plus
//               a tick on the count-0 edge. New divisors are staged in a
//               pending register and only take effect at the period wrap (or
//               at a sync_clr), so periods are never truncated. sync_clr
//               parks every channel at its last count so all enabled
//               channels restart together on the next edge.
// Ports       : clk    clock
//               rst_n  asynchronous active-low reset
//               bus    clk_div_prog_if.slave (controls and status)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int CLK_HZ = 50000000,
    parameter int DEF_HZ = 1,
    parameter int NCH    = 4,
    parameter int DW     = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    clk_div_prog_if.slave      bus
);
    localparam int            c_CW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DW-1:0] c_DEF_DIV = DW'(CLK_HZ / DEF_HZ);
    localparam logic [DW-1:0] c_ONE     = DW'(1);
    localparam logic [DW-1:0] c_TWO     = DW'(2);
    // One extra bit so NCH itself is representable for the range check.
    localparam logic [c_CW:0] c_NCH     = (c_CW + 1)'(NCH);

    // A write is accepted only for a usable divisor on an existing channel.
    logic w_wr_ok;
    assign w_wr_ok = bus.div_wr && (bus.div_val >= c_TWO)
                     && ({1'b0, bus.div_ch} < c_NCH);

    logic r_div_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_err <= 1'b0;
        end else begin
            r_div_err <= bus.div_wr && !w_wr_ok;
        end
    end
    assign bus.div_err = r_div_err;

    logic [NCH-1:0] w_clk_out;
    logic [NCH-1:0] w_tick;
    logic [NCH-1:0] w_pend;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] r_act;   // active divisor A
        logic [DW-1:0] r_nxt;   // pending divisor P
        logic [DW-1:0] r_cnt;
        logic          r_pend;
        logic          r_clk;
        logic          r_tick;

        logic          w_hit;
        logic          w_at_end;
        logic [DW-1:0] w_new_act;
        logic [DW-1:0] w_cnt_inc;
        logic [DW-1:0] w_high;

        assign w_hit     = w_wr_ok && (bus.div_ch == c_CW'(i));
        assign w_at_end  = (r_cnt == (r_act - c_ONE));
        // Divisor in force after a wrap or a sync_clr on this edge.
        assign w_new_act = r_pend ? r_nxt : r_act;
        assign w_cnt_inc = r_cnt + c_ONE;
        // High-phase length: ceil(A/2), so odd divisors run one cycle long high.
        assign w_high    = r_act - (r_act >> 1);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act  <= c_DEF_DIV;
                r_nxt  <= c_DEF_DIV;
                r_pend <= 1'b0;
                // Parked at the last count so the first enabled edge wraps.
                r_cnt  <= c_DEF_DIV - c_ONE;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                if (bus.sync_clr) begin
                    r_act  <= w_new_act;
                    r_pend <= 1'b0;
                    r_cnt  <= w_new_act - c_ONE;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else if (bus.en[i]) begin
                    if (w_at_end) begin
                        r_act  <= w_new_act;
                        r_pend <= 1'b0;
                        r_cnt  <= '0;
                        // Count 0 is always inside the high phase (A >= 2).
                        r_clk  <= 1'b1;
                        r_tick <= 1'b1;
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_clk  <= (w_cnt_inc < w_high);
                        r_tick <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                end

                // Placed last: a write coinciding with a wrap/sync_clr keeps
                // its pend flag, while the wrap itself used the old P/pend.
                if (w_hit) begin
                    r_nxt  <= bus.div_val;
                    r_pend <= 1'b1;
                end
            end
        end

        assign w_clk_out[i] = r_clk;
        assign w_tick[i]    = r_tick;
        assign w_pend[i]    = r_pend;
    end

    assign bus.clk_out = w_clk_out;
    assign bus.tick    = w_tick;
    assign bus.pend    = w_pend;
endmodule
`default_nettype wire

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter DEF_HZ, default 1, per-channel output frequency after reset; DEF_DIV = CLK_HZ/DEF_HZ, with 2 <= DEF_DIV < 2^DW.
REQ-003 SHALL have parameter NCH, default 4, number of independent divider channels (1..16).
REQ-004 SHALL have parameter DW, default 32, divisor and counter width.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, NCH, per-channel count enable.
REQ-008 SHALL have port sync_clr, input, 1, phase-align all channels.
REQ-009 SHALL have port div_wr, input, 1, divisor write strobe.
REQ-010 SHALL have port div_ch, input, CW = max(1, clog2(NCH)), target channel.
REQ-011 SHALL have port div_val, input, DW, new divisor N.
REQ-012 SHALL have port clk_out, output, NCH, divided clocks (registered).
REQ-013 SHALL have port tick, output, NCH, one-cycle pulse at the start of each period.
REQ-014 SHALL have port pend, output, NCH, divisor update pending.
REQ-015 SHALL have port div_err, output, 1, one-cycle pulse on a rejected write.

Function
REQ-016 Each channel SHALL hold an active divisor A, a pending divisor P, a pend flag, and a counter cnt in the range 0..A-1.
REQ-017 Period update SHALL proceed as follows on each clk edge with en[i]=1 and sync_clr=0:
- cnt == A-1: cnt <= 0; if pend, then A <= P and pend cleared (the wrap edge).
- otherwise: cnt <= cnt+1.
REQ-018 clk_out[i] SHALL be registered and equal 1 when the new cnt < H, where H = A - floor(A/2) uses the new A.
- Even N: 50% duty.
- Odd N: high for (N+1)/2 cycles, low for (N-1)/2 cycles.
REQ-019 tick[i] SHALL be registered and equal 1 exactly on the edge where cnt becomes 0.
REQ-020 With en[i]=0, cnt, clk_out[i], A, P and pend SHALL hold; tick[i] SHALL be 0.
REQ-021 A div_wr with 2 <= div_val and div_ch < NCH SHALL load P[div_ch] and set pend[div_ch] on that edge; A SHALL be unchanged.
REQ-022 Multiple writes before a wrap SHALL resolve as last-write-wins.
REQ-023 A write on the same edge as a wrap (or a sync_clr) SHALL update P and leave pend set; the wrap SHALL use the previous P/pend state.
REQ-024 A div_wr with div_val < 2 or div_ch >= NCH SHALL change no state; div_err SHALL be 1 on the next cycle only.
REQ-025 sync_clr=1 SHALL apply to all channels regardless of en, with priority over counting:
- if pend, A <= P and pend cleared;
- cnt <= new A - 1;
- clk_out <= 0;
- tick <= 0.
REQ-026 On the next enabled edge after sync_clr, every enabled channel SHALL wrap to 0 with tick=1, so periods are phase-aligned.
REQ-027 Counter arithmetic SHALL be DW bits, and cnt SHALL never exceed A-1.
REQ-028 Channels SHALL be fully independent except for the shared sync_clr, write port and div_err.

Reset
REQ-029 While rst_n=0, for every channel:
- A = DEF_DIV, P = DEF_DIV, pend = 0;
- cnt = DEF_DIV-1;
- clk_out = 0, tick = 0;
- div_err = 0.
REQ-030 Reset SHALL take effect immediately and asynchronously, aborting any period or pending update mid-operation.
REQ-031 Release SHALL be clean: the first enabled edge after release SHALL give tick=1 and clk_out=1 (a full first high phase).

Verification (CLK_HZ=8, DEF_HZ=2 -> DEF_DIV=4, NCH=3, DW=8)
REQ-032 Reset release, then en=3'b001: clk_out[0] = 1,1,0,0 repeating from edge 1; tick[0] on edges 1,5,9; channels 1 and 2 hold clk_out=0 and tick=0.
REQ-033 Write ch0 N=5 while ch0 is at cnt=1: pend[0]=1 until the wrap; the current 4-cycle period completes; then clk_out = 1,1,1,0,0 repeating with tick every 5 cycles.
REQ-034 Writes ch1 N=6 then ch1 N=3 before the wrap: N=3 is applied at the wrap (high 2, low 1); no 6-cycle period appears.
REQ-035 Write div_val=1 to ch0, and separately div_ch=3: div_err pulses for one cycle each; pend, A and the outputs are unchanged.
REQ-036 Channels 0 and 1 running at N=4 and N=6 with offset phases; pulse sync_clr: both clk_out=0 next cycle, then both tick=1 and clk_out=1 on the same following edge.
REQ-037 With en[0] low for 3 cycles mid-high-phase, clk_out[0] holds at 1 and the period resumes where it stopped; with rst_n low mid-period, outputs are 0 immediately and pend is cleared.
